// File: rtl/bit_countdown_if.sv
// Control/status bundle for the loadable down-counter.
// The master drives the controls; the counter (slave) drives the count and status.
interface bit_countdown_if #(
  parameter int WIDTH = 3
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic             reload_en;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             tc;
  logic             done;

  modport master (
    output load, load_val, start, pause, reload_en,
    input  q, busy, tc, done
  );

  modport slave (
    input  load, load_val, start, pause, reload_en,
    output q, busy, tc, done
  );
endinterface

// File: rtl/bit_countdown.sv
// Loadable down-counter/timer with start/pause control, terminal-count pulse,
// and optional auto-reload for periodic tick generation.
module bit_countdown #(
  parameter int WIDTH = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  bit_countdown_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] q, q_nxt;
  logic [WIDTH-1:0] rld, rld_nxt;
  logic             tc, tc_nxt;
  logic             busy, done;

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    rld_nxt   = rld;
    tc_nxt    = 1'b0;
    if (bus.load) begin
      q_nxt     = bus.load_val;
      rld_nxt   = bus.load_val;
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (q != ZERO) begin
              state_nxt = S_RUN;
            end else begin
              state_nxt = S_DONE;
              tc_nxt    = ~tc;
            end
          end
        end
        S_DONE: begin
          if (bus.start) begin
            if (rld != ZERO) begin
              q_nxt     = rld;
              state_nxt = S_RUN;
            end else begin
              // A held start on a zero reload must not stretch tc.
              tc_nxt = ~tc;
            end
          end
        end
        S_RUN: begin
          if (!bus.pause) begin
            if (q == ONE) begin
              q_nxt  = ZERO;
              tc_nxt = 1'b1;
              if (!bus.reload_en) state_nxt = S_DONE;
            end else if (q == ZERO) begin
              // Zero is only seen in RUN in reload mode: one cycle at 0, then reload.
              q_nxt = rld;
            end else begin
              q_nxt = q - ONE;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      q     <= ZERO;
      rld   <= ZERO;
      tc    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      rld   <= rld_nxt;
      tc    <= tc_nxt;
      busy  <= (state_nxt == S_RUN);
      done  <= (state_nxt == S_DONE);
    end
  end

  assign bus.q    = q;
  assign bus.busy = busy;
  assign bus.tc   = tc;
  assign bus.done = done;
endmodule

// File: tb/tb_bit_countdown.sv
// Directed bench for bit_countdown: per-cycle vector table plus hand-written
// reset/abort sequences.
module tb_bit_countdown;
  localparam int WIDTH = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  bit_countdown_if #(.WIDTH(WIDTH)) bus ();

  bit_countdown #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             pause;
    logic             reload_en;
    logic [WIDTH-1:0] eq;
    logic             ebusy;
    logic             etc;
    logic             edone;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ld, input int lv, input logic st, input logic pa,
                     input logic re, input int q, input logic b, input logic t, input logic d);
    vec_t v;
    v.load = ld; v.load_val = WIDTH'(lv); v.start = st; v.pause = pa; v.reload_en = re;
    v.eq = WIDTH'(q); v.ebusy = b; v.etc = t; v.edone = d;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [WIDTH-1:0] q, input logic b,
                       input logic t, input logic d);
    checks++;
    if (bus.q !== q || bus.busy !== b || bus.tc !== t || bus.done !== d) begin
      failures++;
      $display("FAIL %s: got q=%0d busy=%b tc=%b done=%b, want q=%0d busy=%b tc=%b done=%b",
               name, bus.q, bus.busy, bus.tc, bus.done, q, b, t, d);
    end
  endtask

  task automatic drive(input logic ld, input int lv, input logic st, input logic pa, input logic re);
    bus.load = ld; bus.load_val = WIDTH'(lv); bus.start = st; bus.pause = pa; bus.reload_en = re;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;

    // ld lv st pa re | q busy tc done
    // one-shot count of 5
    add(1,5,0,0,0, 5,0,0,0);
    add(0,0,1,0,0, 5,1,0,0);
    add(0,0,0,0,0, 4,1,0,0);
    add(0,0,0,0,0, 3,1,0,0);
    add(0,0,0,0,0, 2,1,0,0);
    add(0,0,0,0,0, 1,1,0,0);
    add(0,0,0,0,0, 0,0,1,1);
    add(0,0,0,0,0, 0,0,0,1);
    add(0,0,1,0,0, 5,1,0,0);
    add(0,0,1,0,0, 4,1,0,0);   // start ignored while RUN
    // periodic reload of 3
    add(1,3,0,0,1, 3,0,0,0);
    add(0,0,1,0,1, 3,1,0,0);
    add(0,0,0,0,1, 2,1,0,0);
    add(0,0,0,0,1, 1,1,0,0);
    add(0,0,0,0,1, 0,1,1,0);
    add(0,0,0,0,1, 3,1,0,0);
    add(0,0,0,0,1, 2,1,0,0);
    add(0,0,0,0,1, 1,1,0,0);
    add(0,0,0,0,1, 0,1,1,0);
    add(0,0,0,0,1, 3,1,0,0);
    // max count 7 with a 3-cycle pause at q=2
    add(1,7,0,0,0, 7,0,0,0);
    add(0,0,1,0,0, 7,1,0,0);
    add(0,0,0,0,0, 6,1,0,0);
    add(0,0,0,0,0, 5,1,0,0);
    add(0,0,0,0,0, 4,1,0,0);
    add(0,0,0,0,0, 3,1,0,0);
    add(0,0,0,0,0, 2,1,0,0);
    add(0,0,0,1,0, 2,1,0,0);
    add(0,0,0,1,0, 2,1,0,0);
    add(0,0,0,1,0, 2,1,0,0);
    add(0,0,0,0,0, 1,1,0,0);
    add(0,0,0,0,0, 0,0,1,1);
    add(0,0,0,0,0, 0,0,0,1);
    // zero load: start goes straight to DONE with a single tc each time
    add(1,0,0,0,0, 0,0,0,0);
    add(0,0,1,0,0, 0,0,1,1);
    add(0,0,0,0,0, 0,0,0,1);
    add(0,0,1,0,0, 0,0,1,1);
    add(0,0,1,0,0, 0,0,0,1);
    add(0,0,0,0,0, 0,0,0,1);
    // reload mode, pause while sitting at 0
    add(1,1,0,0,1, 1,0,0,0);
    add(0,0,1,0,1, 1,1,0,0);
    add(0,0,0,0,1, 0,1,1,0);
    add(0,0,0,1,1, 0,1,0,0);
    add(0,0,0,0,1, 1,1,0,0);
    add(0,0,0,0,1, 0,1,1,0);

    // asynchronous reset mid-cycle while running
    step();
    rst_n = 1'b1;
    step();
    drive(1, 5, 0, 0, 0); step();
    drive(0, 0, 1, 0, 0); step();
    drive(0, 0, 0, 0, 0); step();
    check("pre_reset", 3'd4, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 3'd0, 0, 0, 0);
    step();
    @(negedge clk) rst_n = 1'b1;
    step();
    check("idle_after_reset0", 3'd0, 0, 0, 0);
    step();
    check("idle_after_reset1", 3'd0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].load, int'(vecs[i].load_val), vecs[i].start, vecs[i].pause, vecs[i].reload_en);
      step();
      check($sformatf("vec%0d", i), vecs[i].eq, vecs[i].ebusy, vecs[i].etc, vecs[i].edone);
    end

    // abort a running count with a fresh load
    drive(1, 6, 0, 0, 0); step();
    drive(0, 0, 1, 0, 0); step();
    check("abort_run6", 3'd6, 1, 0, 0);
    drive(0, 0, 0, 0, 0); step(); step();
    check("abort_at4", 3'd4, 1, 0, 0);
    drive(1, 2, 0, 0, 0); step();
    check("abort_load", 3'd2, 0, 0, 0);
    drive(0, 0, 0, 0, 0); step();
    check("abort_idle", 3'd2, 0, 0, 0);

    // same abort via reset
    drive(1, 6, 0, 0, 0); step();
    drive(0, 0, 1, 0, 0); step();
    drive(0, 0, 0, 0, 0); step(); step();
    check("rst_abort_at4", 3'd4, 1, 0, 0);
    #3 rst_n = 1'b0;
    #1 check("rst_abort", 3'd0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    step();
    check("rst_abort_idle", 3'd0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
